// File: rtl/thread_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thread_scheduler_pkg
// Purpose  : Shared types and constants for the fetch thread scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package thread_scheduler_pkg;

    localparam int c_NTHREADS_DEF = 4;
    localparam int c_TID_W        = $clog2(c_NTHREADS_DEF);
    localparam int c_CNT_W        = 4;

    typedef logic [c_TID_W-1:0] threadid_t;

    typedef enum logic [1:0] {
        TS_IDLE    = 2'd0,
        TS_READY   = 2'd1,
        TS_MISS    = 2'd2,
        TS_BACKOFF = 2'd3
    } thread_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick, searching from ptr+1 with wrap.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import thread_scheduler_pkg::*;
#(
    parameter int NTHREADS = c_NTHREADS_DEF
) (
    input  logic [NTHREADS-1:0] req,
    input  threadid_t           ptr,
    output threadid_t           gnt,
    output logic                gnt_valid
);

    threadid_t w_idx;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        gnt       = ptr;
        gnt_valid = 1'b0;
        w_idx     = ptr;
        for (int i = NTHREADS; i >= 1; i--) begin
            w_idx = threadid_t'((int'(ptr) + i) % NTHREADS);
            if (req[w_idx]) begin
                gnt       = w_idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : thread_scheduler
// Purpose  : Per-thread fetch FSMs plus registered round-robin fetch grant.
// Revision : 1.0 - initial release
// ============================================================================
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int NTHREADS = c_NTHREADS_DEF,
    parameter int BACKOFF  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NTHREADS-1:0] thread_en,
    input  logic                stall,
    input  logic                itlb_miss,
    input  logic                icache_miss,
    input  threadid_t           miss_thread,
    input  logic                fill_valid,
    input  threadid_t           fill_thread,
    input  logic                hz_reject,
    input  threadid_t           hz_thread,
    output logic                fetch_valid,
    output threadid_t           fetch_thread,
    output logic [NTHREADS-1:0] blocked
);

    localparam logic [c_CNT_W-1:0] c_BO_LOAD = c_CNT_W'(BACKOFF - 1);

    logic [NTHREADS-1:0] w_ready_next;
    logic [NTHREADS-1:0] w_req;
    threadid_t           w_gnt;
    logic                w_gnt_valid;
    threadid_t           r_ptr;
    logic                r_fetch_valid;
    threadid_t           r_fetch_thread;

    for (genvar i = 0; i < NTHREADS; i++) begin : g_thread
        thread_state_t      r_state;
        thread_state_t      w_state_nx;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nx;
        logic               w_miss_ev;
        logic               w_fill_ev;
        logic               w_hz_ev;

        assign w_miss_ev = (itlb_miss | icache_miss) && (miss_thread == threadid_t'(i));
        assign w_fill_ev = fill_valid && (fill_thread == threadid_t'(i));
        assign w_hz_ev   = hz_reject && (hz_thread == threadid_t'(i));

        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            if (!thread_en[i]) begin
                w_state_nx = TS_IDLE;
                w_cnt_nx   = '0;
            end else begin
                case (r_state)
                    TS_IDLE: w_state_nx = TS_READY;
                    TS_READY: begin
                        if (w_miss_ev) begin
                            w_state_nx = TS_MISS;
                        end else if (w_hz_ev) begin
                            w_state_nx = TS_BACKOFF;
                            w_cnt_nx   = c_BO_LOAD;
                        end
                    end
                    TS_MISS: begin
                        if (w_fill_ev) begin
                            w_state_nx = TS_READY;
                        end
                    end
                    TS_BACKOFF: begin
                        if (w_miss_ev) begin
                            w_state_nx = TS_MISS;
                        end else if (w_hz_ev) begin
                            w_cnt_nx = c_BO_LOAD;
                        end else if (r_cnt == '0) begin
                            w_state_nx = TS_READY;
                        end else begin
                            w_cnt_nx = r_cnt - 1'b1;
                        end
                    end
                    default: w_state_nx = TS_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= TS_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
            end
        end

        // Only threads that are READY now and stay READY may be granted.
        assign w_ready_next[i] = (w_state_nx == TS_READY);
        assign w_req[i]        = (r_state == TS_READY) && w_ready_next[i];
        assign blocked[i]      = (r_state != TS_READY);
    end

    rr_arbiter #(
        .NTHREADS (NTHREADS)
    ) u_rr_arbiter (
        .req       (w_req),
        .ptr       (r_ptr),
        .gnt       (w_gnt),
        .gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_valid  <= 1'b0;
            r_fetch_thread <= '0;
            r_ptr          <= threadid_t'(NTHREADS - 1);
        end else if (stall) begin
            // A held grant is withdrawn once its thread stops being READY.
            if (r_fetch_valid && !w_ready_next[r_fetch_thread]) begin
                r_fetch_valid <= 1'b0;
            end
        end else if (w_gnt_valid) begin
            r_fetch_valid  <= 1'b1;
            r_fetch_thread <= w_gnt;
            r_ptr          <= w_gnt;
        end else begin
            r_fetch_valid <= 1'b0;
        end
    end

    assign fetch_valid  = r_fetch_valid;
    assign fetch_thread = r_fetch_thread;

endmodule
`default_nettype wire

// File: tb/tb_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_thread_scheduler
// Purpose  : Directed and randomized self-checking bench for thread_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thread_scheduler;

    localparam int NT  = 4;
    localparam int BOC = 3;
    localparam int S_IDLE = 0, S_RDY = 1, S_MISS = 2, S_BO = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NT-1:0] thread_en;
    logic          stall, itlb_miss, icache_miss, fill_valid, hz_reject;
    logic [1:0]    miss_thread, fill_thread, hz_thread;
    logic          fetch_valid;
    logic [1:0]    fetch_thread;
    logic [NT-1:0] blocked;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: thread status, remaining blocked cycles, grant output.
    int st [NT];
    int bo_left [NT];
    int m_fv, m_ft, m_ptr;

    thread_scheduler #(.NTHREADS(NT), .BACKOFF(BOC)) dut (
        .clk          (clk),
        .rst          (rst),
        .thread_en    (thread_en),
        .stall        (stall),
        .itlb_miss    (itlb_miss),
        .icache_miss  (icache_miss),
        .miss_thread  (miss_thread),
        .fill_valid   (fill_valid),
        .fill_thread  (fill_thread),
        .hz_reject    (hz_reject),
        .hz_thread    (hz_thread),
        .fetch_valid  (fetch_valid),
        .fetch_thread (fetch_thread),
        .blocked      (blocked)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; itlb_miss = 0; icache_miss = 0; fill_valid = 0; hz_reject = 0;
        miss_thread = 0; fill_thread = 0; hz_thread = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            st[i] = S_IDLE;
            bo_left[i] = 0;
        end
        m_fv = 0; m_ft = 0; m_ptr = NT - 1;
    endtask

    // Advance the model across one rising edge using the inputs present there.
    task automatic model_step();
        int  ns [NT];
        int  nb [NT];
        bit  mev, fev, hev, found;
        int  t;
        for (int i = 0; i < NT; i++) begin
            ns[i] = st[i];
            nb[i] = bo_left[i];
            mev = (itlb_miss || icache_miss) && (int'(miss_thread) == i);
            fev = fill_valid && (int'(fill_thread) == i);
            hev = hz_reject && (int'(hz_thread) == i);
            if (!thread_en[i]) begin
                ns[i] = S_IDLE;
                nb[i] = 0;
            end else if (st[i] == S_IDLE) begin
                ns[i] = S_RDY;
            end else if (st[i] == S_RDY) begin
                if (mev) ns[i] = S_MISS;
                else if (hev) begin ns[i] = S_BO; nb[i] = BOC; end
            end else if (st[i] == S_MISS) begin
                if (fev) ns[i] = S_RDY;
            end else begin
                if (mev) ns[i] = S_MISS;
                else if (hev) nb[i] = BOC;
                else if (bo_left[i] <= 1) ns[i] = S_RDY;
                else nb[i] = bo_left[i] - 1;
            end
        end
        if (stall) begin
            if (m_fv == 1 && ns[m_ft] != S_RDY) m_fv = 0;
        end else begin
            found = 0;
            for (int k = 1; k <= NT; k++) begin
                t = (m_ptr + k) % NT;
                if (!found && st[t] == S_RDY && ns[t] == S_RDY) begin
                    found = 1; m_fv = 1; m_ft = t; m_ptr = t;
                end
            end
            if (!found) m_fv = 0;
        end
        for (int i = 0; i < NT; i++) begin
            st[i] = ns[i];
            bo_left[i] = nb[i];
        end
    endtask

    task automatic compare_outputs();
        logic [NT-1:0] eb;
        for (int i = 0; i < NT; i++) eb[i] = (st[i] != S_RDY);
        check("blocked", 32'(blocked), 32'(eb));
        check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
        check("fetch_thread", 32'(fetch_thread), 32'(m_ft));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    // Assert reset mid-cycle, check the immediate effect, release mid-cycle later.
    task automatic do_reset();
        #2 rst = 0;
        #1;
        model_reset();
        check("rst_blocked", 32'(blocked), 32'hF);
        check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        check("rst_fetch_thread", 32'(fetch_thread), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1;
    endtask

    initial begin
        bit found;
        thread_en = '1;
        clear_inputs();
        @(posedge clk); #1;
        do_reset();

        // Power-up sequence: first grant two edges after release, then 0,1,2,3,0.
        cycle();
        check("first_cycle_no_grant", 32'(fetch_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rr_seq_valid", 32'(fetch_valid), 32'h1);
            check("rr_seq_thread", 32'(fetch_thread), 32'(k % NT));
        end

        // I-cache miss on thread 1, then fill.
        icache_miss = 1; miss_thread = 2'd1;
        cycle();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            check("t1_absent", 32'(fetch_valid && fetch_thread == 2'd1), 32'h0);
            cycle();
        end
        fill_valid = 1; fill_thread = 2'd1;
        cycle();
        clear_inputs();
        check("t1_not_before_m2", 32'(fetch_valid && fetch_thread == 2'd1), 32'h0);
        for (int k = 0; k < 4; k++) cycle();

        // Hazard backoff on thread 2, then restart of the window.
        hz_reject = 1; hz_thread = 2'd2;
        cycle();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            check("bo_window", 32'(blocked[2]), 32'(k < BOC));
            if (k < 3) cycle();
        end
        hz_reject = 1; hz_thread = 2'd2;
        cycle();
        clear_inputs();
        cycle();
        hz_reject = 1; hz_thread = 2'd2;
        cycle();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            check("bo_restart", 32'(blocked[2]), 32'(k < BOC));
            if (k < 3) cycle();
        end
        for (int k = 0; k < 3; k++) cycle();

        // Stall while thread 3 holds the grant, then miss on thread 3.
        found = 0;
        for (int k = 0; k < 16 && !found; k++) begin
            if (m_fv == 1 && m_ft == 3) found = 1;
            else cycle();
        end
        check("find_t3_grant", 32'(found), 32'h1);
        stall = 1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_hold_thread", 32'(fetch_thread), 32'h3);
            check("stall_hold_valid", 32'(fetch_valid), 32'h1);
        end
        itlb_miss = 1; miss_thread = 2'd3;
        cycle();
        check("stall_drop_valid", 32'(fetch_valid), 32'h0);
        clear_inputs();

        // Remaining threads into MISS, then release thread 0 only.
        for (int t = 0; t < 3; t++) begin
            icache_miss = 1; miss_thread = 2'(t);
            cycle();
        end
        clear_inputs();
        cycle();
        check("all_miss_valid", 32'(fetch_valid), 32'h0);
        check("all_miss_blocked", 32'(blocked), 32'hF);
        fill_valid = 1; fill_thread = 2'd0;
        cycle();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("single_valid", 32'(fetch_valid), 32'h1);
            check("single_thread", 32'(fetch_thread), 32'h0);
        end

        // Thread 0 into BACKOFF (thread 2 still in MISS), then reset.
        hz_reject = 1; hz_thread = 2'd0;
        cycle();
        clear_inputs();
        check("pre_rst_blocked", 32'(blocked), 32'hF);
        do_reset();
        fill_valid = 1; fill_thread = 2'd2;
        cycle();
        cycle();
        clear_inputs();
        check("post_rst_t2_ready", 32'(blocked[2]), 32'h0);
        for (int k = 0; k < 4; k++) cycle();

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NT; i++) thread_en[i] = ($urandom_range(0, 15) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            itlb_miss   = ($urandom_range(0, 9) == 0);
            icache_miss = ($urandom_range(0, 9) == 0);
            miss_thread = 2'($urandom_range(0, NT - 1));
            fill_valid  = ($urandom_range(0, 2) == 0);
            fill_thread = 2'($urandom_range(0, NT - 1));
            hz_reject   = ($urandom_range(0, 5) == 0);
            hz_thread   = 2'($urandom_range(0, NT - 1));
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter NTHREADS, default 4, number of hardware threads (power of two, 2..8).
REQ-002 Parameter BACKOFF, default 3, cycles a thread is held after a hazard reject (1..15).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 thread_en  in  NTHREADS  per-thread enable; 0 parks the thread.
REQ-006 stall  in  1  front-end stall; 1 holds the current grant.
REQ-007 itlb_miss  in  1  I-TLB miss for thread miss_thread.
REQ-008 icache_miss  in  1  I-cache miss for thread miss_thread.
REQ-009 miss_thread  in  threadid_t  thread owning the miss.
REQ-010 fill_valid  in  1  miss resolved for thread fill_thread.
REQ-011 fill_thread  in  threadid_t  thread whose miss resolved.
REQ-012 hz_reject  in  1  hazard unit rejected instruction of hz_thread (isvalid=0).
REQ-013 hz_thread  in  threadid_t  thread of rejected instruction.
REQ-014 fetch_valid  out  1  fetch_thread is a valid grant this cycle.
REQ-015 fetch_thread  out  threadid_t  thread granted for fetch.
REQ-016 blocked  out  NTHREADS  1 = thread not in READY.

Function
REQ-017 Per-thread FSM states IDLE, READY, MISS, BACKOFF; each thread has its own state and 4-bit backoff counter.
REQ-018 Transition priority per thread, highest first: thread_en=0 -> IDLE; miss event -> MISS; fill event -> READY; hazard event -> BACKOFF; counter expiry -> READY.
REQ-019 IDLE -> READY when thread_en=1.
REQ-020 READY -> MISS on (itlb_miss|icache_miss) with miss_thread = thread; both miss flags together count as one event.
REQ-021 MISS -> READY on fill_valid with fill_thread = thread; fill_valid for a thread not in MISS is ignored.
REQ-022 Miss events for a thread already in MISS are ignored; no outstanding-miss count is kept.
REQ-023 READY -> BACKOFF on hz_reject with hz_thread = thread, counter loaded with BACKOFF-1.
REQ-024 BACKOFF counter decrements each cycle; at 0 the thread returns to READY next cycle (BACKOFF cycles total).
REQ-025 hz_reject for a thread in MISS or IDLE is ignored; hz_reject in BACKOFF reloads the counter.
REQ-026 Arbitration is round-robin over READY threads, searching from last granted + 1 with wrap-around modulo NTHREADS.
REQ-027 Grant is registered: the grant computed in cycle N appears on fetch_valid/fetch_thread in cycle N+1 (latency 1).
REQ-028 Eligibility uses next-cycle state: a thread entering MISS/BACKOFF/IDLE in cycle N is not granted in N+1.
REQ-029 stall=1 holds fetch_thread, fetch_valid and the round-robin pointer, unless the held thread leaves READY, in which case fetch_valid drops to 0 next cycle.
REQ-030 No READY thread -> fetch_valid=0, fetch_thread holds its last value, pointer unchanged.
REQ-031 Pointer advances to the granted thread only when stall=0 and a grant is issued.
REQ-032 Single READY thread is granted every cycle while stall=0.
REQ-033 blocked is combinational from current state.

Reset
REQ-034 rst=0 asynchronously forces all threads to IDLE, counters to 0, fetch_valid=0, fetch_thread=0, pointer to NTHREADS-1 (first search starts at thread 0).
REQ-035 Reset asserted mid-miss or mid-backoff discards that state; fills arriving after reset release are ignored (threads not in MISS).
REQ-036 First grant possible two cycles after reset release with thread_en set (IDLE->READY, then grant register).

Structure
REQ-037 threadid_t, NTHREADS default and the thread state enum live in the shared common package.
REQ-038 One sub-module rr_arbiter (request mask, pointer -> grant index, grant valid), purely combinational; FSMs and registers in thread_scheduler.

Verification
REQ-039 Reset release, thread_en=4'b1111, no events -> fetch_thread sequence 0,1,2,3,0 from cycle 2, fetch_valid=1 throughout.
REQ-040 icache_miss for thread 1 in cycle N -> thread 1 absent from grants from N+1; fill_valid thread 1 in cycle M -> thread 1 granted again no earlier than M+2.
REQ-041 hz_reject thread 2, BACKOFF=3 -> blocked[2]=1 for exactly 3 cycles, then eligible; second hz_reject during backoff restarts 3-cycle window.
REQ-042 stall=1 for 5 cycles with fetch_thread=3 -> output held at 3; itlb_miss thread 3 during stall -> fetch_valid=0 next cycle.
REQ-043 All four threads in MISS -> fetch_valid=0; single fill thread 0 -> grants 0 only, every cycle.
REQ-044 rst asserted while thread 2 in MISS and thread 0 in BACKOFF -> all blocked=1 immediately, fetch_valid=0; subsequent fill_valid thread 2 ignored.
